// File: rtl/mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// Optional MDU_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mdu_op,
  input  logic            word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

  state_t        state;
  logic [63:0]   a_reg, b_reg, mag_reg;
  logic [2:0]    op_reg;
  logic          word_reg, negq_reg, negr_reg;
  logic [6:0]    cnt_reg;
  logic [127:0]  acc_reg;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Operand preparation: signedness, magnitudes and short-circuit cases
  logic        is_div, sgn1, sgn2, neg1, neg2, div0, ovf;
  logic [63:0] ext1, ext2, mag1, mag2, dvd, short_res;

  always_comb begin
    is_div = op_reg[2];
    sgn1   = is_div ? ~op_reg[0] : (~word_reg & (op_reg[1] ^ op_reg[0]));
    sgn2   = is_div ? ~op_reg[0] : (~word_reg & (op_reg[1:0] == 2'b01));
    ext1   = word_reg ? (sgn1 ? sext32(a_reg[31:0]) : {32'd0, a_reg[31:0]}) : a_reg;
    ext2   = word_reg ? (sgn2 ? sext32(b_reg[31:0]) : {32'd0, b_reg[31:0]}) : b_reg;
    neg1   = sgn1 & ext1[63];
    neg2   = sgn2 & ext2[63];
    mag1   = neg1 ? (~ext1 + 64'd1) : ext1;
    mag2   = neg2 ? (~ext2 + 64'd1) : ext2;
    dvd    = word_reg ? sext32(a_reg[31:0]) : a_reg;
    div0   = is_div & (word_reg ? (b_reg[31:0] == 32'd0) : (b_reg == 64'd0));
    ovf    = is_div & sgn1 &
             (word_reg ? ((a_reg[31:0] == 32'h8000_0000) && (b_reg[31:0] == 32'hFFFF_FFFF))
                       : ((a_reg == 64'h8000_0000_0000_0000) && (b_reg == 64'hFFFF_FFFF_FFFF_FFFF)));
    if (div0)
      short_res = op_reg[1] ? dvd : 64'hFFFF_FFFF_FFFF_FFFF;
    else
      short_res = op_reg[1] ? 64'd0 : dvd;
  end

  // One iteration: acc = {hi, lo}; multiply shifts right, divide shifts {rem, quo} left
  logic [64:0]  mul_sum, div_sh, div_diff;
  logic [127:0] calc_next;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[127:64]} + (acc_reg[0] ? {1'b0, mag_reg} : 65'd0);
    div_sh   = {acc_reg[127:64], acc_reg[63]};
    div_diff = div_sh - {1'b0, mag_reg};
    if (is_div)
      calc_next = div_diff[64] ? {div_sh[63:0], acc_reg[62:0], 1'b0}
                               : {div_diff[63:0], acc_reg[62:0], 1'b1};
    else
      calc_next = {mul_sum, acc_reg[63:1]};
  end

`ifdef MDU_EARLY_OUT_EN
  logic [63:0]  lo_mask;
  logic         early;
  logic [127:0] early_acc;

  always_comb begin
    lo_mask   = cnt_reg[6] ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cnt_reg[5:0]) - 64'd1);
    early     = ~is_div & ((acc_reg[63:0] & lo_mask) == 64'd0);
    early_acc = acc_reg >> cnt_reg;
  end
`endif

  // Sign fixup and output selection; a word multiply leaves its product shifted up by 32
  logic [127:0] prod;
  logic [63:0]  quo, rem, fix_val, fix_res;

  always_comb begin
    prod = negq_reg ? (~acc_reg + 128'd1) : acc_reg;
    quo  = negq_reg ? (~acc_reg[63:0] + 64'd1) : acc_reg[63:0];
    rem  = negr_reg ? (~acc_reg[127:64] + 64'd1) : acc_reg[127:64];
    if (is_div)
      fix_val = op_reg[1] ? rem : quo;
    else if (word_reg)
      fix_val = {32'd0, acc_reg[63:32]};
    else
      fix_val = (op_reg[1:0] == 2'b00) ? prod[63:0] : prod[127:64];
    fix_res = word_reg ? sext32(fix_val[31:0]) : fix_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      result   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      mag_reg  <= '0;
      op_reg   <= '0;
      word_reg <= 1'b0;
      negq_reg <= 1'b0;
      negr_reg <= 1'b0;
      cnt_reg  <= '0;
      acc_reg  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !flush) begin
          a_reg    <= op1;
          b_reg    <= op2;
          op_reg   <= mdu_op;
          word_reg <= word;
          state    <= PREP;
        end
        PREP: if (flush) begin
          state <= IDLE;
        end else if (div0 || ovf) begin
          result <= short_res;
          done   <= 1'b1;
          state  <= DONE;
        end else begin
          mag_reg  <= is_div ? mag2 : mag1;
          acc_reg  <= is_div ? {64'd0, (word_reg ? {mag1[31:0], 32'd0} : mag1)} : {64'd0, mag2};
          negq_reg <= neg1 ^ neg2;
          negr_reg <= neg1;
          cnt_reg  <= word_reg ? 7'd32 : 7'd64;
          state    <= CALC;
        end
        CALC: if (flush) begin
          state <= IDLE;
`ifdef MDU_EARLY_OUT_EN
        end else if (early) begin
          acc_reg <= early_acc;
          cnt_reg <= 7'd0;
          state   <= FIXUP;
`endif
        end else begin
          acc_reg <= calc_next;
          cnt_reg <= cnt_reg - 7'd1;
          if (cnt_reg == 7'd1)
            state <= FIXUP;
        end
        FIXUP: if (flush) begin
          state <= IDLE;
        end else begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = (start && (state == IDLE)) || (state == PREP) || (state == CALC) || (state == FIXUP);

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table, scoreboard queue of expected results,
// and hand-written flush / reset / back-to-back sequences.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, start, word, flush;
  logic [2:0]  mdu_op;
  logic [63:0] op1, op2;
  logic        busy, stall_req, done;
  logic [63:0] result;

  mdu_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op), .word(word),
    .op1(op1), .op2(op2), .flush(flush), .busy(busy), .stall_req(stall_req),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Scoreboard: every done pops the oldest expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) chk("done_unexpected", {63'd0, done}, 64'd0);
      else chk("result", result, exp_q.pop_front());
    end
  end

  // Call right after a negedge; returns at the negedge where done is seen
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] e, input int lat, input int idx);
    int n;
    bit stall_ok;
    mdu_op = o; word = w; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(e);
    #1 stall_ok = (stall_req === 1'b1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done === 1'b1) break;
      if (stall_req !== 1'b1) stall_ok = 1'b0;
    end
    $display("op %0d: mdu_op=%b word=%b a=%h b=%h exp=%h cycles=%0d", idx, o, w, a, b, e, n);
    if (n >= 200) begin
      chk($sformatf("timeout_%0d", idx), 64'(n), 64'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
`ifdef MDU_EARLY_OUT_EN
      if (o[2]) chk($sformatf("latency_%0d", idx), 64'(n), 64'(lat));
`else
      chk($sformatf("latency_%0d", idx), 64'(n), 64'(lat));
`endif
      chk($sformatf("stall_%0d", idx), {62'd0, stall_ok, stall_req}, 64'd2);
    end
  endtask

  initial begin
    int n, first, second;
    logic b68, b69, done_seen;
    logic [63:0] last_exp;

    tbl[0]  = '{3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 67};
    tbl[1]  = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 67};
    tbl[2]  = '{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 67};
    tbl[3]  = '{3'b100, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    tbl[4]  = '{3'b111, 1'b0, 64'd7, 64'd0, 64'd7, 2};
    tbl[5]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    tbl[6]  = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    tbl[7]  = '{3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35};
    tbl[8]  = '{3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35};
    tbl[9]  = '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 67};
    tbl[10] = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    tbl[11] = '{3'b000, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35};
    tbl[12] = '{3'b001, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35};
    tbl[13] = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 67};
    tbl[14] = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    tbl[15] = '{3'b100, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    tbl[16] = '{3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2};
    tbl[17] = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    tbl[18] = '{3'b000, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 67};
    tbl[19] = '{3'b011, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'd1, 67};
    tbl[20] = '{3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 67};
    tbl[21] = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 67};
    last_exp = tbl[NV-1].exp;

    rst = 1'b1; start = 1'b0; flush = 1'b0; word = 1'b0; mdu_op = 3'b000; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("reset: busy=%b done=%b stall_req=%b result=%h", busy, done, stall_req, result);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_stall", {63'd0, stall_req}, 64'd0);
    chk("reset_result", result, 64'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      run_op(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, i);
    end

    // Flush 10 cycles into CALC: no done, result keeps the previous value
    @(negedge clk);
    mdu_op = 3'b101; word = 1'b0; op1 = 64'd12345; op2 = 64'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    $display("flush: busy=%b result=%h", busy, result);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_result", result, last_exp);
    done_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    chk("flush_no_done", {63'd0, done_seen}, 64'd0);
    @(negedge clk);
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 67, 100);

    // Reset pulse mid-CALC clears all outputs immediately
    @(negedge clk);
    mdu_op = 3'b000; word = 1'b0; op1 = 64'd9; op2 = 64'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    $display("rst mid-calc: busy=%b done=%b stall_req=%b result=%h", busy, done, stall_req, result);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 67, 101);

    // Flush in IDLE blocks acceptance of a concurrent start
    @(negedge clk);
    mdu_op = 3'b101; op1 = 64'd50; op2 = 64'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    $display("idle flush+start: busy=%b", busy);
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);

    // Start held high: second op accepted only in the IDLE cycle after DONE
    @(negedge clk);
    mdu_op = 3'b101; word = 1'b0; op1 = 64'd100; op2 = 64'd7; start = 1'b1;
    exp_q.push_back(64'd14);
    exp_q.push_back(64'd2);
    n = 0; first = -1; second = -1; b68 = 1'b1; b69 = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) mdu_op = 3'b111;
      if (n == 68) b68 = busy;
      if (n == 69) b69 = busy;
      if (done === 1'b1) begin
        if (first < 0) first = n;
        else begin
          second = n;
          break;
        end
      end
    end
    start = 1'b0;
    $display("back-to-back: first done=%0d second done=%0d busy68=%b busy69=%b", first, second, b68, b69);
    chk("b2b_first", 64'(first), 64'd67);
    chk("b2b_second", 64'(second), 64'd135);
    chk("b2b_busy_idle", {63'd0, b68}, 64'd0);
    chk("b2b_busy_prep", {63'd0, b69}, 64'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
